// File: rtl/fm_3d_mu_cache_arb_if.sv
// rtl/fm_3d_mu_cache_arb_if.sv - two-port request/burst bundle between the 3D units and the cache arbiter
interface fm_3d_mu_cache_arb_if #(
    parameter int P_AW  = 30,
    parameter int P_DW  = 32,
    parameter int P_BEW = 4,
    parameter int P_LW  = 6
);
    logic              i_req_p0,  i_req_p1;
    logic              i_wr_p0,   i_wr_p1;
    logic [P_AW-1:0]   i_adrs_p0, i_adrs_p1;
    logic [P_LW-1:0]   i_len_p0,  i_len_p1;
    logic [P_BEW-1:0]  i_be_p0,   i_be_p1;
    logic              o_ack_p0,  o_ack_p1;
    logic              i_strw_p0, i_strw_p1;
    logic [P_DW-1:0]   i_dbw_p0,  i_dbw_p1;
    logic              o_ackw_p0, o_ackw_p1;
    logic              o_strr_p0, o_strr_p1;
    logic [P_DW-1:0]   o_dbr_p;

    logic              o_req_ci;
    logic              o_wr_ci;
    logic [P_AW-1:0]   o_adrs_ci;
    logic [P_LW-1:0]   o_len_ci;
    logic [P_BEW-1:0]  o_be_ci;
    logic              o_strw_ci;
    logic [P_DW-1:0]   o_dbw_ci;
    logic              i_ack_ci;
    logic              i_ackw_ci;
    logic              i_strr_ci;
    logic [P_DW-1:0]   i_dbr_ci;

    modport slave (
        input  i_req_p0, i_req_p1, i_wr_p0, i_wr_p1, i_adrs_p0, i_adrs_p1,
        input  i_len_p0, i_len_p1, i_be_p0, i_be_p1, i_strw_p0, i_strw_p1,
        input  i_dbw_p0, i_dbw_p1, i_ack_ci, i_ackw_ci, i_strr_ci, i_dbr_ci,
        output o_ack_p0, o_ack_p1, o_ackw_p0, o_ackw_p1, o_strr_p0, o_strr_p1, o_dbr_p,
        output o_req_ci, o_wr_ci, o_adrs_ci, o_len_ci, o_be_ci, o_strw_ci, o_dbw_ci
    );

    modport master (
        output i_req_p0, i_req_p1, i_wr_p0, i_wr_p1, i_adrs_p0, i_adrs_p1,
        output i_len_p0, i_len_p1, i_be_p0, i_be_p1, i_strw_p0, i_strw_p1,
        output i_dbw_p0, i_dbw_p1, i_ack_ci, i_ackw_ci, i_strr_ci, i_dbr_ci,
        input  o_ack_p0, o_ack_p1, o_ackw_p0, o_ackw_p1, o_strr_p0, o_strr_p1, o_dbr_p,
        input  o_req_ci, o_wr_ci, o_adrs_ci, o_len_ci, o_be_ci, o_strw_ci, o_dbw_ci
    );
endinterface

// File: rtl/fm_3d_mu_cache_arb.sv
// rtl/fm_3d_mu_cache_arb.sv - round-robin burst arbiter for the texture and pixel ports of the 3D cache
module fm_3d_mu_cache_arb #(
    parameter int P_AW  = 30,
    parameter int P_DW  = 32,
    parameter int P_BEW = 4,
    parameter int P_LW  = 6
) (
    input logic                  clk_core,
    input logic                  rst_x,
    fm_3d_mu_cache_arb_if.slave  bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_WDAT, ST_RDAT} state_t;

    localparam logic [P_LW-1:0] CNT_ONE = P_LW'(1);

    state_t           r_state;
    logic             r_gnt;
    logic             r_last;
    logic [P_LW-1:0]  r_cnt;

    logic             gnt_req, gnt_wr, gnt_strw;
    logic [P_AW-1:0]  gnt_adrs;
    logic [P_LW-1:0]  gnt_len;
    logic [P_BEW-1:0] gnt_be;
    logic [P_DW-1:0]  gnt_dbw;
    logic             in_cmd, in_wdat, in_rdat;
    logic             cmd_ack, beat;

    always_comb begin
        gnt_req  = r_gnt ? bus.i_req_p1  : bus.i_req_p0;
        gnt_wr   = r_gnt ? bus.i_wr_p1   : bus.i_wr_p0;
        gnt_adrs = r_gnt ? bus.i_adrs_p1 : bus.i_adrs_p0;
        gnt_len  = r_gnt ? bus.i_len_p1  : bus.i_len_p0;
        gnt_be   = r_gnt ? bus.i_be_p1   : bus.i_be_p0;
        gnt_strw = r_gnt ? bus.i_strw_p1 : bus.i_strw_p0;
        gnt_dbw  = r_gnt ? bus.i_dbw_p1  : bus.i_dbw_p0;
    end

    assign in_cmd  = (r_state == ST_CMD);
    assign in_wdat = (r_state == ST_WDAT);
    assign in_rdat = (r_state == ST_RDAT);

    // An ack arriving in the same cycle the owner withdraws is not passed on.
    assign cmd_ack = in_cmd & gnt_req & bus.i_ack_ci;
    assign beat    = (in_wdat & gnt_strw & bus.i_ackw_ci) | (in_rdat & bus.i_strr_ci);

    assign bus.o_req_ci  = in_cmd & gnt_req;
    assign bus.o_wr_ci   = in_cmd & gnt_wr;
    assign bus.o_adrs_ci = in_cmd ? gnt_adrs : '0;
    assign bus.o_len_ci  = in_cmd ? gnt_len  : '0;
    assign bus.o_be_ci   = in_cmd ? gnt_be   : '0;
    assign bus.o_strw_ci = in_wdat & gnt_strw;
    assign bus.o_dbw_ci  = in_wdat ? gnt_dbw : '0;

    assign bus.o_ack_p0  = cmd_ack & ~r_gnt;
    assign bus.o_ack_p1  = cmd_ack &  r_gnt;
    assign bus.o_ackw_p0 = in_wdat & ~r_gnt & bus.i_ackw_ci;
    assign bus.o_ackw_p1 = in_wdat &  r_gnt & bus.i_ackw_ci;
    assign bus.o_strr_p0 = in_rdat & ~r_gnt & bus.i_strr_ci;
    assign bus.o_strr_p1 = in_rdat &  r_gnt & bus.i_strr_ci;
    assign bus.o_dbr_p   = bus.i_dbr_ci;

    // r_last starts at 1 so the texture port wins the first contested grant.
    always_ff @(posedge clk_core or posedge rst_x) begin
        if (rst_x) begin
            r_state <= ST_IDLE;
            r_gnt   <= 1'b0;
            r_last  <= 1'b1;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.i_req_p0 | bus.i_req_p1) begin
                        r_gnt   <= (bus.i_req_p0 & bus.i_req_p1) ? ~r_last : bus.i_req_p1;
                        r_state <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (!gnt_req) begin
                        r_state <= ST_IDLE;
                    end else if (bus.i_ack_ci) begin
                        r_last  <= r_gnt;
                        r_cnt   <= gnt_len;
                        r_state <= gnt_wr ? ST_WDAT : ST_RDAT;
                    end
                end
                ST_WDAT, ST_RDAT: begin
                    // A zero length wraps through the full counter range.
                    if (beat) begin
                        r_cnt <= r_cnt - CNT_ONE;
                        if (r_cnt == CNT_ONE) r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fm_3d_mu_cache_arb.sv
// tb/tb_fm_3d_mu_cache_arb.sv - directed self-checking bench for the 3D cache arbiter
module tb_fm_3d_mu_cache_arb;
    logic clk_core = 1'b0;
    logic rst_x    = 1'b1;

    int checks = 0;
    int errors = 0;

    int cnt_ack0 = 0, cnt_ack1 = 0, cnt_ackw0 = 0, cnt_ackw1 = 0;
    int cnt_strr0 = 0, cnt_strr1 = 0;
    int ord [0:15];
    int n_ord = 0;

    int b_ack0, b_ack1, b_ackw0, b_ackw1, b_strr0, b_strr1, b_ord;

    fm_3d_mu_cache_arb_if bus ();

    fm_3d_mu_cache_arb dut (
        .clk_core (clk_core),
        .rst_x    (rst_x),
        .bus      (bus)
    );

    always #5 clk_core = ~clk_core;

    always @(negedge clk_core) begin
        if (bus.o_ack_p0) begin
            cnt_ack0 = cnt_ack0 + 1;
            if (n_ord < 16) ord[n_ord] = 0;
            n_ord = n_ord + 1;
        end
        if (bus.o_ack_p1) begin
            cnt_ack1 = cnt_ack1 + 1;
            if (n_ord < 16) ord[n_ord] = 1;
            n_ord = n_ord + 1;
        end
        if (bus.o_ackw_p0) cnt_ackw0 = cnt_ackw0 + 1;
        if (bus.o_ackw_p1) cnt_ackw1 = cnt_ackw1 + 1;
        if (bus.o_strr_p0) cnt_strr0 = cnt_strr0 + 1;
        if (bus.o_strr_p1) cnt_strr1 = cnt_strr1 + 1;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            errors = errors + 1;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_core);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic snap();
        b_ack0 = cnt_ack0;   b_ack1 = cnt_ack1;
        b_ackw0 = cnt_ackw0; b_ackw1 = cnt_ackw1;
        b_strr0 = cnt_strr0; b_strr1 = cnt_strr1;
        b_ord = n_ord;
    endtask

    task automatic clear_inputs();
        bus.i_req_p0 = 0;  bus.i_req_p1 = 0;  bus.i_wr_p0 = 0;   bus.i_wr_p1 = 0;
        bus.i_adrs_p0 = 0; bus.i_adrs_p1 = 0; bus.i_len_p0 = 0;  bus.i_len_p1 = 0;
        bus.i_be_p0 = 0;   bus.i_be_p1 = 0;   bus.i_strw_p0 = 0; bus.i_strw_p1 = 0;
        bus.i_dbw_p0 = 0;  bus.i_dbw_p1 = 0;  bus.i_ack_ci = 0;  bus.i_ackw_ci = 0;
        bus.i_strr_ci = 0; bus.i_dbr_ci = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_x = 1'b1;
        run(2);
        rst_x = 1'b0;
    endtask

    initial begin
        clear_inputs();
        bus.i_dbr_ci = 32'hCAFE_0001;
        run(2);
        @(negedge clk_core);
        check_eq("rst_outs", {bus.o_req_ci, bus.o_ack_p0, bus.o_ack_p1, bus.o_strw_ci,
                              bus.o_ackw_p0, bus.o_ackw_p1, bus.o_strr_p0, bus.o_strr_p1}, 0);
        check_eq("rst_dbr", bus.o_dbr_p, 32'hCAFE_0001);
        tick();
        rst_x = 1'b0;

        // port 0 read, len 4, ack on the second CMD cycle
        bus.i_req_p0 = 1; bus.i_adrs_p0 = 30'h100; bus.i_len_p0 = 4; bus.i_be_p0 = 4'hF;
        snap();
        @(negedge clk_core); check_eq("t1_idle_req", bus.o_req_ci, 0);
        tick();
        @(negedge clk_core);
        check_eq("t1_cmd_req", bus.o_req_ci, 1);
        check_eq("t1_cmd_adrs", bus.o_adrs_ci, 30'h100);
        check_eq("t1_cmd_len", bus.o_len_ci, 4);
        check_eq("t1_cmd_noack", bus.o_ack_p0, 0);
        tick();
        bus.i_ack_ci = 1;
        @(negedge clk_core); check_eq("t1_ack_p0", bus.o_ack_p0, 1);
        tick();
        bus.i_ack_ci = 0; bus.i_req_p0 = 0; bus.i_strr_ci = 1; bus.i_dbr_ci = 32'h1234_5678;
        @(negedge clk_core); check_eq("t1_dbr", bus.o_dbr_p, 32'h1234_5678);
        run(6);
        bus.i_strr_ci = 0;
        check_eq("t1_ack0", cnt_ack0 - b_ack0, 1);
        check_eq("t1_strr0", cnt_strr0 - b_strr0, 4);
        check_eq("t1_p1_quiet", (cnt_ack1 - b_ack1) + (cnt_strr1 - b_strr1), 0);
        bus.i_req_p1 = 1; bus.i_adrs_p1 = 30'h2AB;
        @(negedge clk_core); check_eq("t1_idle_again", bus.o_req_ci, 0);
        tick();
        @(negedge clk_core); check_eq("t1_p1_adrs", bus.o_adrs_ci, 30'h2AB);

        // both ports read len 1 from reset: strict alternation
        do_reset();
        bus.i_req_p0 = 1; bus.i_req_p1 = 1; bus.i_len_p0 = 1; bus.i_len_p1 = 1;
        bus.i_ack_ci = 1; bus.i_strr_ci = 1;
        snap();
        run(9);
        check_eq("t2_nacks", n_ord - b_ord, 3);
        check_eq("t2_ord0", ord[b_ord], 0);
        check_eq("t2_ord1", ord[b_ord + 1], 1);
        check_eq("t2_ord2", ord[b_ord + 2], 0);
        check_eq("t2_strr0", cnt_strr0 - b_strr0, 2);
        check_eq("t2_strr1", cnt_strr1 - b_strr1, 1);

        // port 1 write len 2 with a three-cycle ackw stall
        do_reset();
        bus.i_req_p1 = 1; bus.i_wr_p1 = 1; bus.i_len_p1 = 2; bus.i_strw_p1 = 1;
        bus.i_dbw_p1 = 32'h1111_2222; bus.i_ackw_ci = 1;
        snap();
        @(negedge clk_core); check_eq("t3_idle_strw", bus.o_strw_ci, 0);
        tick();
        bus.i_ack_ci = 1;
        @(negedge clk_core);
        check_eq("t3_cmd_strw", bus.o_strw_ci, 0);
        check_eq("t3_cmd_wr", bus.o_wr_ci, 1);
        check_eq("t3_ack_p1", bus.o_ack_p1, 1);
        tick();
        bus.i_ack_ci = 0; bus.i_req_p1 = 0;
        @(negedge clk_core);
        check_eq("t3_strw", bus.o_strw_ci, 1);
        check_eq("t3_dbw", bus.o_dbw_ci, 32'h1111_2222);
        tick();
        bus.i_ackw_ci = 0;
        run(3);
        bus.i_ackw_ci = 1;
        run(3);
        @(negedge clk_core); check_eq("t3_post_strw", bus.o_strw_ci, 0);
        check_eq("t3_ackw1", cnt_ackw1 - b_ackw1, 2);
        check_eq("t3_ackw0", cnt_ackw0 - b_ackw0, 0);
        tick();
        bus.i_strw_p1 = 0; bus.i_wr_p1 = 0;

        // port 0 read len 0: 64 beats, port 1 held off until the end
        do_reset();
        bus.i_req_p0 = 1; bus.i_len_p0 = 0; bus.i_ack_ci = 1;
        tick();
        @(negedge clk_core); check_eq("t4_len0", bus.o_len_ci, 0);
        tick();
        bus.i_req_p0 = 0; bus.i_req_p1 = 1; bus.i_strr_ci = 1;
        snap();
        run(64);
        check_eq("t4_strr0", cnt_strr0 - b_strr0, 64);
        check_eq("t4_no_ack1", cnt_ack1 - b_ack1, 0);
        @(negedge clk_core);
        check_eq("t4_idle_strr", bus.o_strr_p0, 0);
        check_eq("t4_idle_ack1", bus.o_ack_p1, 0);
        tick();
        @(negedge clk_core); check_eq("t4_ack1", bus.o_ack_p1, 1);
        tick();
        bus.i_req_p1 = 0; bus.i_strr_ci = 0; bus.i_ack_ci = 0;

        // reset in the middle of an 8-beat write
        do_reset();
        bus.i_req_p0 = 1; bus.i_wr_p0 = 1; bus.i_len_p0 = 8; bus.i_ack_ci = 1;
        bus.i_strw_p0 = 1; bus.i_ackw_ci = 1;
        run(2);
        bus.i_req_p0 = 0;
        snap();
        run(2);
        @(negedge clk_core); check_eq("t5_strw_mid", bus.o_strw_ci, 1);
        rst_x = 1'b1;
        #1;
        check_eq("t5_async_outs", {bus.o_strw_ci, bus.o_ackw_p0, bus.o_req_ci, bus.o_ack_p0}, 0);
        check_eq("t5_beats_before", cnt_ackw0 - b_ackw0, 3);
        tick();
        rst_x = 1'b0;
        bus.i_req_p1 = 1; bus.i_adrs_p1 = 30'h3C0;
        @(negedge clk_core);
        check_eq("t5_idle_outs", {bus.o_strw_ci, bus.o_req_ci, bus.o_ackw_p0}, 0);
        tick();
        @(negedge clk_core);
        check_eq("t5_p1_req", bus.o_req_ci, 1);
        check_eq("t5_p1_adrs", bus.o_adrs_ci, 30'h3C0);
        check_eq("t5_p1_ack", bus.o_ack_p1, 1);
        tick();
        bus.i_req_p1 = 0;

        // port 0 withdraws in CMD; pending port 1 then wins
        do_reset();
        bus.i_req_p0 = 1; bus.i_req_p1 = 1;
        bus.i_adrs_p0 = 30'h040; bus.i_adrs_p1 = 30'h080;
        snap();
        tick();
        @(negedge clk_core); check_eq("t6_cmd_adrs0", bus.o_adrs_ci, 30'h040);
        tick();
        bus.i_req_p0 = 0; bus.i_ack_ci = 1;
        @(negedge clk_core);
        check_eq("t6_drop_req", bus.o_req_ci, 0);
        check_eq("t6_drop_ack", bus.o_ack_p0, 0);
        tick();
        bus.i_ack_ci = 0;
        @(negedge clk_core); check_eq("t6_idle", bus.o_req_ci, 0);
        tick();
        @(negedge clk_core);
        check_eq("t6_p1_req", bus.o_req_ci, 1);
        check_eq("t6_p1_adrs", bus.o_adrs_ci, 30'h080);
        check_eq("t6_no_ack0", cnt_ack0 - b_ack0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
